// File: rtl/dvfs_pkg.sv
// Shared types and helpers for the DVFS transition sequencer.
package dvfs_pkg;

  // Width of the regulator voltage-level code (3 = highest .. 0 = lowest).
  localparam int VLVL_W = 2;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    V_REQ   = 3'd1,
    V_REL   = 3'd2,
    SETTLE  = 3'd3,
    F_APPLY = 3'd4,
    F_HOLD  = 3'd5
  } dvfs_state_e;

  // Minimum voltage level needed to run the divided clock safely.
  // Small divide ratios mean a fast clock and therefore a high voltage.
  function automatic logic [VLVL_W-1:0] lvl_of_div(input logic [31:0] d);
    logic [VLVL_W-1:0] l;
    if (d >= 32'd8) begin
      l = 2'd0;
    end else if (d >= 32'd4) begin
      l = 2'd1;
    end else if (d >= 32'd2) begin
      l = 2'd2;
    end else begin
      l = 2'd3;
    end
    return l;
  endfunction

endpackage

// File: rtl/dvfs_vreg_handshake.sv
// 4-phase req/ack handshake to the voltage regulator with a per-phase
// timeout. Owns the requested voltage level so that an aborted handshake
// can restore the level that was in force before it started.
module dvfs_vreg_handshake
  import dvfs_pkg::*;
#(
  parameter int                unsigned TIMEOUT_CYC = 1024,
  parameter logic [VLVL_W-1:0] RST_LEVEL   = 2'd1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              start,
  input  logic [VLVL_W-1:0] level,
  input  logic              vreg_ack,
  output logic              vreg_req,
  output logic [VLVL_W-1:0] vreg_level,
  output logic              done,
  output logic              timeout
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_REL  = 2'd2
  } hs_state_e;

  hs_state_e         hs_q, hs_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [VLVL_W-1:0] level_q, level_d;
  logic [VLVL_W-1:0] prev_q, prev_d;
  logic              phase_expired;

  // The phase counter starts at 0 on phase entry, so this is the last
  // cycle the regulator is given to respond.
  assign phase_expired = (cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // State, phase counter and level registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= HS_IDLE;
      cnt_q   <= '0;
      level_q <= RST_LEVEL;
      prev_q  <= RST_LEVEL;
    end else begin
      hs_q    <= hs_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  // Next-state: a response from the regulator always wins over expiry.
  always_comb begin
    hs_d    = hs_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    prev_d  = prev_q;
    case (hs_q)
      HS_IDLE: begin
        if (start) begin
          hs_d    = HS_REQ;
          cnt_d   = '0;
          prev_d  = level_q;
          level_d = level;
        end
      end
      HS_REQ: begin
        if (vreg_ack) begin
          hs_d  = HS_REL;
          cnt_d = '0;
        end else if (phase_expired) begin
          hs_d    = HS_IDLE;
          cnt_d   = '0;
          level_d = prev_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HS_REL: begin
        if (!vreg_ack) begin
          hs_d  = HS_IDLE;
          cnt_d = '0;
        end else if (phase_expired) begin
          hs_d    = HS_IDLE;
          cnt_d   = '0;
          level_d = prev_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        hs_d  = HS_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Outputs: req is a pure state decode; done/timeout are single-cycle
  // strobes seen by the sequencer in the cycle the handshake ends.
  always_comb begin
    vreg_req   = (hs_q == HS_REQ);
    vreg_level = level_q;
    done       = (hs_q == HS_REL) && !vreg_ack;
    timeout    = ((hs_q == HS_REQ) && !vreg_ack && phase_expired) ||
                 ((hs_q == HS_REL) &&  vreg_ack && phase_expired);
  end

endmodule

// File: rtl/dvfs_transition_sequencer.sv
// Orders voltage and frequency changes so the divided clock never runs
// faster than the current regulator level supports.
module dvfs_transition_sequencer
  import dvfs_pkg::*;
#(
  parameter int unsigned MAX_DIV     = 16,
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned HOLD_CYC    = 32,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned RST_DIV     = 4,
  localparam int         DIV_W       = $clog2(MAX_DIV)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  req_div,
  output logic [DIV_W-1:0]  div_ratio,
  output logic [VLVL_W-1:0] vreg_level,
  output logic              vreg_req,
  input  logic              vreg_ack,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [VLVL_W-1:0] RST_LEVEL = lvl_of_div(32'(RST_DIV));

  dvfs_state_e       state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  tgt_q, tgt_d;
  logic              up_q, up_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [DIV_W-1:0]  tgt_norm;
  logic [VLVL_W-1:0] lvl_tgt_norm;
  logic [VLVL_W-1:0] lvl_tgt_q;
  logic [VLVL_W-1:0] lvl_div;
  logic              hs_start;
  logic [VLVL_W-1:0] hs_level;
  logic              hs_done;
  logic              hs_timeout;

  // Map the raw request onto a legal divide ratio (0 means "fastest").
  always_comb begin
    if (req_div == '0) begin
      tgt_norm = DIV_W'(1);
    end else if (32'(req_div) > 32'(MAX_DIV - 1)) begin
      tgt_norm = DIV_W'(MAX_DIV - 1);
    end else begin
      tgt_norm = req_div;
    end
    lvl_tgt_norm = lvl_of_div(32'(tgt_norm));
    lvl_tgt_q    = lvl_of_div(32'(tgt_q));
    lvl_div      = lvl_of_div(32'(div_q));
  end

  // Regulator handshake, including the abort-time level restore.
  dvfs_vreg_handshake #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .RST_LEVEL   (RST_LEVEL)
  ) u_hs (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .start      (hs_start),
    .level      (hs_level),
    .vreg_ack   (vreg_ack),
    .vreg_req   (vreg_req),
    .vreg_level (vreg_level),
    .done       (hs_done),
    .timeout    (hs_timeout)
  );

  // State register plus transition bookkeeping.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= DIV_W'(RST_DIV);
      tgt_q   <= DIV_W'(RST_DIV);
      up_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tgt_q   <= tgt_d;
      up_q    <= up_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state: the handshake start is raised on the same edge as the
  // entry into V_REQ so the request is visible from V_REQ's first cycle.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tgt_d    = tgt_q;
    up_d     = up_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    hs_start = 1'b0;
    hs_level = lvl_tgt_q;
    case (state_q)
      IDLE: begin
        // Latching is harmless when nothing starts: tgt_q/up_q are only
        // consulted outside IDLE.
        tgt_d = tgt_norm;
        up_d  = (tgt_norm < div_q);
        if (tgt_norm != div_q) begin
          if (tgt_norm < div_q) begin
            if (err_q) begin
              // Regulator is unreliable: speed up only within the
              // voltage we already have.
              if (lvl_tgt_norm <= vreg_level) begin
                state_d = F_APPLY;
              end
            end else if (lvl_tgt_norm != lvl_div) begin
              state_d  = V_REQ;
              hs_start = 1'b1;
              hs_level = lvl_tgt_norm;
            end else begin
              state_d = F_APPLY;
            end
          end else begin
            state_d = F_APPLY;
          end
        end
      end
      V_REQ: begin
        if (hs_timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (vreg_ack) begin
          state_d = V_REL;
        end
      end
      V_REL: begin
        if (hs_timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (hs_done) begin
          if (up_q) begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYC - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = F_APPLY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      F_APPLY: begin
        div_d = tgt_q;
        if (up_q || err_q || (lvl_tgt_q == vreg_level)) begin
          state_d = IDLE;
        end else begin
          state_d = F_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end
      end
      F_HOLD: begin
        if (cnt_q == '0) begin
          state_d  = V_REQ;
          hs_start = 1'b1;
          hs_level = lvl_tgt_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    div_ratio = div_q;
    busy      = (state_q != IDLE);
    err       = err_q;
  end

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// Directed and randomized checks of the DVFS transition sequencer against
// a transaction-level model of its voltage/frequency rules.
module tb_dvfs_transition_sequencer;

  localparam int MAX_DIV     = 16;
  localparam int SETTLE_CYC  = 8;
  localparam int HOLD_CYC    = 16;
  localparam int TIMEOUT_CYC = 40;
  localparam int RST_DIV     = 4;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic [3:0] req_div = 4'd4;
  logic [3:0] div_ratio;
  logic [1:0] vreg_level;
  logic       vreg_req;
  wire        vreg_ack;
  logic       busy;
  logic       err;

  // Regulator model: 0 = random-delay auto responder, 1 = dead, 2 = manual.
  int   resp_mode = 2;
  logic man_ack   = 1'b0;
  logic auto_ack  = 1'b0;
  assign vreg_ack = (resp_mode == 2) ? man_ack : ((resp_mode == 1) ? 1'b0 : auto_ack);

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;

  // Model state
  logic [3:0] m_div = 4'd4;
  logic [1:0] m_lvl = 2'd1;
  bit         m_err = 1'b0;

  always #5 clk_in = ~clk_in;

  dvfs_transition_sequencer #(
    .MAX_DIV     (MAX_DIV),
    .SETTLE_CYC  (SETTLE_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .RST_DIV     (RST_DIV)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .req_div    (req_div),
    .div_ratio  (div_ratio),
    .vreg_level (vreg_level),
    .vreg_req   (vreg_req),
    .vreg_ack   (vreg_ack),
    .busy       (busy),
    .err        (err)
  );

  function automatic logic [1:0] ref_lvl(input logic [3:0] d);
    if (d == 4'd1)      return 2'd3;
    else if (d <= 4'd3) return 2'd2;
    else if (d <= 4'd7) return 2'd1;
    else                return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Continuous invariants: frequency never outruns voltage, and the level
  // is frozen while a request is outstanding.
  initial begin : monitor
    logic       prev_req;
    logic [1:0] prev_lvl;
    prev_req = 1'b0;
    prev_lvl = 2'd0;
    forever begin
      @(negedge clk_in);
      if (rst_n) begin
        chk("order", 32'(ref_lvl(div_ratio) <= vreg_level), 32'd1);
        if (prev_req && vreg_req) chk("lvl_stable", 32'(vreg_level), 32'(prev_lvl));
        if (vreg_req && !prev_req) hs_cnt++;
      end
      prev_req = vreg_req;
      prev_lvl = vreg_level;
    end
  end

  initial begin : responder
    int w;
    w = 0;
    forever begin
      @(negedge clk_in);
      if (resp_mode != 0) begin
        auto_ack = 1'b0;
        w = 0;
      end else if (!auto_ack && vreg_req) begin
        if (w == 0) begin auto_ack = 1'b1; w = $urandom_range(0, 4); end
        else w--;
      end else if (auto_ack && !vreg_req) begin
        if (w == 0) begin auto_ack = 1'b0; w = $urandom_range(0, 4); end
        else w--;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (busy && cyc < 1000) begin
      @(negedge clk_in);
      cyc++;
    end
    if (busy) chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_req(input string tag, input logic val);
    int n;
    n = 0;
    while (vreg_req != val && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk(tag, 32'(vreg_req), 32'(val));
  endtask

  // One request/response transaction checked against the rule-level model.
  task automatic do_txn(input logic [3:0] r);
    logic [3:0] t;
    logic [3:0] exp_div;
    logic [1:0] exp_lvl;
    bit         change;
    bit         hs_exp;
    int         hs0;
    int         cyc;
    @(negedge clk_in);
    t       = (r == 4'd0) ? 4'd1 : r;
    exp_div = m_div;
    exp_lvl = m_lvl;
    change  = 1'b0;
    hs_exp  = 1'b0;
    if (t != m_div) begin
      if (m_err) begin
        if (t > m_div || ref_lvl(t) <= m_lvl) begin
          change  = 1'b1;
          exp_div = t;
        end
      end else begin
        change  = 1'b1;
        exp_div = t;
        if (ref_lvl(t) != ref_lvl(m_div)) begin
          hs_exp  = 1'b1;
          exp_lvl = ref_lvl(t);
        end
      end
    end
    hs0     = hs_cnt;
    req_div = r;
    @(negedge clk_in);
    chk("txn_busy_start", 32'(busy), 32'(change));
    wait_idle("txn_idle_wait", cyc);
    if (change && !hs_exp) chk("txn_busy_len", 32'(cyc), 32'd1);
    chk("txn_div", 32'(div_ratio), 32'(exp_div));
    chk("txn_lvl", 32'(vreg_level), 32'(exp_lvl));
    chk("txn_err", 32'(err), 32'(m_err));
    chk("txn_hs", 32'(hs_cnt - hs0), 32'(hs_exp));
    $display("txn req=%0d div=%0d lvl=%0d err=%0d busy_cyc=%0d hs=%0d",
             r, div_ratio, vreg_level, err, cyc, hs_cnt - hs0);
    m_div = exp_div;
    m_lvl = exp_lvl;
  endtask

  initial begin : stim
    int n;
    int cyc;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    chk("rst_div", 32'(div_ratio), 32'd4);
    chk("rst_lvl", 32'(vreg_level), 32'd1);
    chk("rst_req", 32'(vreg_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Up 4->1, voltage first, then settle
    req_div = 4'd1;
    @(posedge clk_in); #1;
    chk("up_req", 32'(vreg_req), 32'd1);
    chk("up_lvl_first", 32'(vreg_level), 32'd3);
    chk("up_div_hold", 32'(div_ratio), 32'd4);
    repeat (3) @(negedge clk_in);
    man_ack = 1'b1;
    wait_req("up_req_drop", 1'b0);
    repeat (2) @(negedge clk_in);
    man_ack = 1'b0;
    @(posedge clk_in);
    n = 0;
    do begin
      @(posedge clk_in); #1;
      n++;
    end while (div_ratio != 4'd1 && n < 200);
    chk("up_latency", 32'(n), 32'(SETTLE_CYC + 1));
    @(negedge clk_in);
    wait_idle("up_idle", cyc);
    chk("up_lvl_end", 32'(vreg_level), 32'd3);
    $display("txn req=1 div=%0d lvl=%0d latency=%0d", div_ratio, vreg_level, n);
    m_div = 4'd1;
    m_lvl = 2'd3;

    // Down 1->8: frequency first, hold, then voltage
    @(negedge clk_in);
    req_div = 4'd8;
    @(posedge clk_in); #1;
    chk("dn_div_hold", 32'(div_ratio), 32'd1);
    @(posedge clk_in); #1;
    chk("dn_div_apply", 32'(div_ratio), 32'd8);
    n = 0;
    do begin
      @(posedge clk_in); #1;
      n++;
    end while (!vreg_req && n < 200);
    chk("dn_hold_len", 32'(n), 32'(HOLD_CYC));
    chk("dn_lvl", 32'(vreg_level), 32'd0);
    @(negedge clk_in);
    man_ack = 1'b1;
    wait_req("dn_req_drop", 1'b0);
    @(negedge clk_in);
    man_ack = 1'b0;
    wait_idle("dn_idle", cyc);
    chk("dn_lvl_end", 32'(vreg_level), 32'd0);
    $display("txn req=8 div=%0d lvl=%0d hold=%0d", div_ratio, vreg_level, n);
    m_div = 4'd8;
    m_lvl = 2'd0;

    // Same-level change 4->6
    resp_mode = 0;
    do_txn(4'd4);
    do_txn(4'd6);

    // Request change mid-flight completes the latched target first
    do_txn(4'd4);
    resp_mode = 2;
    @(negedge clk_in);
    req_div = 4'd1;
    wait_req("mid_req", 1'b1);
    @(negedge clk_in);
    man_ack = 1'b1;
    wait_req("mid_req_drop", 1'b0);
    @(negedge clk_in);
    man_ack = 1'b0;
    @(negedge clk_in);
    req_div = 4'd8;
    n = 0;
    while (div_ratio != 4'd1 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    chk("mid_first_done", 32'(div_ratio), 32'd1);
    chk("mid_idle_gap", 32'(busy), 32'd0);
    resp_mode = 0;
    @(negedge clk_in);
    chk("mid_next_start", 32'(busy), 32'd1);
    wait_idle("mid_idle", cyc);
    chk("mid_div", 32'(div_ratio), 32'd8);
    chk("mid_lvl", 32'(vreg_level), 32'd0);
    $display("txn req=8 (queued) div=%0d lvl=%0d", div_ratio, vreg_level);
    m_div = 4'd8;
    m_lvl = 2'd0;

    // Reset during SETTLE
    resp_mode = 2;
    @(negedge clk_in);
    req_div = 4'd1;
    wait_req("rs_req", 1'b1);
    @(negedge clk_in);
    man_ack = 1'b1;
    wait_req("rs_req_drop", 1'b0);
    @(negedge clk_in);
    man_ack = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n   = 1'b0;
    req_div = 4'd4;
    #1;
    chk("rs_div", 32'(div_ratio), 32'd4);
    chk("rs_lvl", 32'(vreg_level), 32'd1);
    chk("rs_req", 32'(vreg_req), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_err", 32'(err), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    m_div = 4'd4;
    m_lvl = 2'd1;
    m_err = 1'b0;
    @(negedge clk_in);
    chk("rs_stay_idle", 32'(busy), 32'd0);
    $display("txn reset mid-settle div=%0d lvl=%0d", div_ratio, vreg_level);

    // Random traffic with a well-behaved regulator
    resp_mode = 0;
    repeat (25) do_txn(4'($urandom_range(0, 15)));

    // Timeout on up 4->1 with a dead regulator
    do_txn(4'd4);
    resp_mode = 1;
    @(negedge clk_in);
    req_div = 4'd1;
    wait_req("to_req", 1'b1);
    @(posedge clk_in);
    n = 1;
    #1;
    while (!err && n < 200) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("to_latency", 32'(n), 32'(TIMEOUT_CYC));
    chk("to_div", 32'(div_ratio), 32'd4);
    chk("to_lvl", 32'(vreg_level), 32'd1);
    chk("to_req_low", 32'(vreg_req), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    $display("txn req=1 timeout err=%0d div=%0d lvl=%0d cycles=%0d", err, div_ratio, vreg_level, n);
    m_err = 1'b1;

    // Error mode: unsafe speed-up ignored, slow-down is frequency only
    do_txn(4'd1);
    do_txn(4'd8);
    resp_mode = 0;
    repeat (15) do_txn(4'($urandom_range(0, 15)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
